// File: rtl/fetch_unit.sv
// Instruction fetch stage with a small prefetch queue.
//
// Holds the program counter, addresses the instruction ROM (which answers
// combinationally), captures {pc, instr} pairs into a DEPTH-entry queue and
// hands them to decode over a valid/ready handshake. A redirect from execute
// flushes the queue and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   fetch_en       permit new fetches; queue still drains when low
//   rom_addr       byte address to the ROM (always word aligned)
//   rom_data       instruction word for rom_addr
//   redirect_valid single-cycle redirect request
//   redirect_pc    redirect target (low two bits ignored)
//   out_valid      queue head valid
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at the queue head
//   out_pc         byte address of out_instr
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 7,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] redirect_target;

  assign redirect_target = redirect_pc & ~ADDR_W'(3);

  assign pop  = out_valid & out_ready;
  // A full queue may still accept a push on an edge where the head leaves.
  assign push = fetch_en & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pc     <= redirect_target;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= pc;
        instr_q[wr_ptr] <= rom_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
        pc              <= pc + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rom_addr  = pc;
  assign out_valid = (count != '0);
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction ROM and downstream consumers (decode).
- Holds the program counter and drives the ROM byte address. The ROM returns the word combinationally in the same cycle.
- Captures {pc, instr} pairs into a small prefetch queue and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute; a redirect flushes the queue and restarts fetch at the target.

Parameters:
- ADDR_W, 7, byte-address width of the instruction space; must match the ROM address width.
- DEPTH, 2, prefetch queue entries; power of two, 2..8.
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  when high, fetching is permitted; when low, no new pushes occur but the queue still drains.
- rom_addr  out  ADDR_W  byte address to the ROM; equals pc, bits [1:0] always 0.
- rom_data  in  32  instruction word returned combinationally for rom_addr.
- redirect_valid  in  1  single-cycle redirect request from execute.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at the queue head.
- out_pc  out  ADDR_W  byte address of out_instr.

Behaviour:
- Reset (rst high at an edge) gives: pc=RESET_PC, queue count=0, rd/wr pointers=0, out_valid=0, out_instr=0, out_pc=0, rom_addr=RESET_PC.
  - Reset wins over every other input.
  - Reset asserted mid-operation discards all queued entries on that edge.
- Definitions:
  - pop = out_valid & out_ready.
  - push = fetch_en & !redirect_valid & (count<DEPTH | pop).
- Push: on an edge with push, write {pc, rom_data} at wr_ptr, advance wr_ptr, and set pc <= pc+4.
  - pc addition is modulo 2^ADDR_W, so pc wraps to 0 after the last word (0x7C -> 0x00 for ADDR_W=7).
- Pop: on an edge with pop, advance rd_ptr.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. This is legal when full and also when count=1.
- Outputs:
  - out_valid = (count!=0), driven from registered state.
  - out_instr and out_pc are the entry at rd_ptr.
  - Outputs must remain stable while out_valid & !out_ready.
- Redirect has priority over push and pop. On an edge with redirect_valid:
  - count=0 and pointers reset to 0.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No push occurs that edge. A simultaneous pop is discarded with the flush.
- Redirect latency:
  - Redirect asserted in cycle t gives out_valid=0 in cycle t+1.
  - rom_addr=target in cycle t+1.
  - out_valid=1 with out_pc=target in cycle t+2 (provided fetch_en is high).
- Cold-start latency: rst low from cycle 0 with fetch_en high gives out_valid=1, out_pc=RESET_PC in cycle 1.
- Throughput: one instruction per cycle sustained while out_ready is held high.
- Full queue with no pop: pc holds and rom_addr is stable, so no instruction is skipped or duplicated.
- fetch_en low: pc holds; queued entries remain poppable.
- rom_data is sampled only on push edges. Its value during reset is don't-care.
- No state machine beyond the queue; implement with a pointer/count register file.

Test Plan:
- Straight-line fetch: reset with RESET_PC=0, fetch_en=1, out_ready=1 -> out_pc sequence 0x00,0x04,... from cycle 1. At out_pc=0x18, out_instr=0x0bb00613; at 0x1C, out_instr=0x0b500513; all others 0x00000013.
- Backpressure: out_ready=0 for 5 cycles starting when out_pc=0x08.
  - count saturates at 2 and rom_addr holds at 0x10.
  - out_pc stays 0x08.
  - After release, the sequence resumes 0x08,0x0C,0x10 with no gaps or duplicates.
- Redirect: redirect_valid for one cycle with redirect_pc=0x1A while the queue is full -> next cycle out_valid=0 and rom_addr=0x18. The following cycle out_pc=0x18 and out_instr=0x0bb00613.
- Wrap-around: redirect to 0x78 with out_ready=1 -> out_pc sequence 0x78,0x7C,0x00,0x04.
- fetch_en gating: drop fetch_en with count=2 and out_ready=1 -> two more pops occur, then out_valid=0 while rom_addr holds. Raising fetch_en resumes fetch at the held pc.
- Mid-run reset: assert rst for one cycle during streaming -> next cycle out_valid=0 and rom_addr=RESET_PC. out_pc=RESET_PC appears one cycle after rst falls.
